// File: rtl/mem_access_unit.sv
// Multicycle load/store sequencer in front of a byte-addressed word memory.
// One request at a time; sub-word stores use read-modify-write.
module mem_access_unit #(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        fault,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_d_in,
  output logic        mem_mrd,
  output logic        mem_mwr,
  input  logic [31:0] mem_d_out
);

  localparam logic [31:0] LAST_ADR = 32'(MEM_BYTES - 4);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_RMW_RD, S_RMW_WR, S_FAULT, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic        r_wr, r_sext, r_fault;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_merge, r_rdata;

  logic        w_in_fault;
  logic [31:0] w_aadr, w_sh, w_ext, w_merge;
  logic [1:0]  w_off;

  // Fault is decided from the live inputs so IDLE can branch on it directly.
  assign w_in_fault = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00) ||
                      ({addr[31:2], 2'b00} > LAST_ADR);

  assign w_aadr = {r_addr[31:2], 2'b00};
  assign w_off  = r_addr[1:0];
  assign w_sh   = mem_d_out >> {w_off, 3'b000};

  always_comb begin
    case (r_size)
      2'b00:   w_ext = {{24{r_sext & w_sh[7]}}, w_sh[7:0]};
      2'b01:   w_ext = {{16{r_sext & w_sh[15]}}, w_sh[15:0]};
      default: w_ext = mem_d_out;
    endcase
  end

  always_comb begin
    w_merge = r_merge;
    if (r_size == 2'b00)
      w_merge[{w_off, 3'b000} +: 8] = r_wdata[7:0];
    else if (w_off[1])
      w_merge[31:16] = r_wdata[15:0];
    else
      w_merge[15:0] = r_wdata[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req) begin
        if (w_in_fault)          w_next = S_FAULT;
        else if (!wr)            w_next = S_RD;
        else if (size == 2'b10)  w_next = S_WR;
        else                     w_next = S_RMW_RD;
      end
      S_RD, S_WR, S_RMW_WR, S_FAULT: w_next = S_DONE;
      S_RMW_RD: w_next = S_RMW_WR;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_sext  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_fault <= 1'b0;
      r_merge <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req) begin
          r_wr    <= wr;
          r_size  <= size;
          r_sext  <= sext;
          r_addr  <= addr;
          r_wdata <= wdata;
          r_fault <= w_in_fault;
        end
        S_RD:     r_rdata <= w_ext;
        S_RMW_RD: r_merge <= mem_d_out;
        S_FAULT:  if (!r_wr) r_rdata <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_mrd  = 1'b0;
    mem_mwr  = 1'b0;
    mem_adr  = '0;
    mem_d_in = '0;
    case (r_state)
      S_RD, S_RMW_RD: begin
        mem_mrd = 1'b1;
        mem_adr = w_aadr;
      end
      S_WR: begin
        mem_mwr  = 1'b1;
        mem_adr  = w_aadr;
        mem_d_in = r_wdata;
      end
      S_RMW_WR: begin
        mem_mwr  = 1'b1;
        mem_adr  = w_aadr;
        mem_d_in = w_merge;
      end
      default: ;
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign ready = (r_state == S_DONE);
  assign fault = ready & r_fault;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural byte memory.
module tb_mem_access_unit;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, wr = 1'b0, sext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, mem_adr, mem_d_in, mem_d_out;
  logic        ready, busy, fault, mem_mrd, mem_mwr;

  mem_access_unit #(.MEM_BYTES(65536)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
    .fault(fault), .mem_adr(mem_adr), .mem_d_in(mem_d_in), .mem_mrd(mem_mrd),
    .mem_mwr(mem_mwr), .mem_d_out(mem_d_out)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_adr = '0;
  logic [31:0] pl_dat = '0;

  always_comb begin
    mem_d_out = '0;
    if (mem_adr <= 32'd65532)
      mem_d_out = {mem[mem_adr[15:0]+16'd3], mem[mem_adr[15:0]+16'd2],
                   mem[mem_adr[15:0]+16'd1], mem[mem_adr[15:0]]};
  end

  always @(posedge clk) begin
    if (mem_mwr && mem_adr <= 32'd65532)
      for (int i = 0; i < 4; i++) mem[mem_adr[15:0]+16'(i)] = mem_d_in[8*i +: 8];
    if (pl_en)
      for (int i = 0; i < 4; i++) mem[pl_adr+16'(i)] = pl_dat[8*i +: 8];
  end

  typedef struct { logic [31:0] rdata; logic fault; } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0;
  int n_mrd = 0, n_ready = 0, n_issued = 0;
  logic [31:0] last_wr = '0, last_ld = '0;
  logic prev_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rdw(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // Monitor: pops one expected response per ready pulse.
  always @(negedge clk) begin
    if (rst) prev_ready = 1'b0;
    else begin
      chk("strobe_excl", {31'b0, mem_mrd & mem_mwr}, 32'd0);
      if (ready) begin
        n_ready++;
        chk("ready_pulse", {31'b0, prev_ready}, 32'd0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready got=1 expected=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("fault", {31'b0, fault}, {31'b0, e.fault});
          chk("rdata", rdata, e.rdata);
        end
      end else if (fault) begin
        chk("fault_no_ready", 32'd1, 32'd0);
      end
      if (mem_mrd) n_mrd++;
      if (mem_mwr) last_wr = mem_d_in;
      prev_ready = ready;
    end
  end

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_adr = 16'(a); pl_dat = d;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_f, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin @(negedge clk); n++; end
    if (busy) begin chk("idle_timeout", 32'd1, 32'd0); return; end
    req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = d;
    sb.push_back('{exp_rd, exp_f});
    n_issued++;
    @(posedge clk); #1;
    req = 1'b0; wr = $urandom; size = 2'($urandom); sext = $urandom;
    addr = $urandom; wdata = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!ready && n < 20);
    chk("latency", n, exp_lat);
  endtask

  task automatic ld(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                    input logic [31:0] e, input logic f);
    do_req(1'b0, sz, sx, a, 32'h0, e, f, 2);
    last_ld = e;
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                    input logic f, input int lat);
    do_req(1'b1, sz, 1'b0, a, d, last_ld, f, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic idle;
    logic        hw [4];
    logic [31:0] ha [4];
    logic [31:0] hd [4];
    int i, g, lastacc;

    #12;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ctl", {28'd0, ready, busy, fault, mem_mrd | mem_mwr}, 32'd0);
    chk("rst_adr", mem_adr, 32'd0);
    chk("rst_din", mem_d_in, 32'd0);
    @(negedge clk); rst = 1'b0;

    st(2'b10, 32'd2000, 32'hDEADBEEF, 1'b0, 2);
    chk("st_word_mem", rdw(2000), 32'hDEADBEEF);
    chk("st_word_b0", {24'd0, mem[2000]}, 32'hEF);
    ld(2'b10, 1'b0, 32'd2000, 32'hDEADBEEF, 1'b0);

    preload(2004, 32'h11223344);
    st(2'b00, 32'd2006, 32'h000000AA, 1'b0, 3);
    chk("rmw_byte_din", last_wr, 32'h11AA3344);
    ld(2'b10, 1'b0, 32'd2004, 32'h11AA3344, 1'b0);
    st(2'b01, 32'd2006, 32'hFFFF5566, 1'b0, 3);
    chk("rmw_half_din", last_wr, 32'h55663344);
    ld(2'b10, 1'b0, 32'd2004, 32'h55663344, 1'b0);

    preload(1000, 32'h80F0017F);
    ld(2'b00, 1'b1, 32'd1003, 32'hFFFFFF80, 1'b0);
    ld(2'b00, 1'b0, 32'd1003, 32'h00000080, 1'b0);
    ld(2'b01, 1'b1, 32'd1002, 32'hFFFF80F0, 1'b0);
    ld(2'b00, 1'b1, 32'd1000, 32'h0000007F, 1'b0);
    ld(2'b00, 1'b1, 32'd1001, 32'h00000001, 1'b0);
    ld(2'b00, 1'b1, 32'd1002, 32'hFFFFFFF0, 1'b0);
    ld(2'b01, 1'b0, 32'd1000, 32'h0000017F, 1'b0);

    n0 = n_mrd;
    ld(2'b01, 1'b1, 32'd1001, 32'h0, 1'b1);
    chk("fault_no_mrd", n_mrd - n0, 32'd0);
    n0 = n_mrd;
    st(2'b10, 32'd2002, 32'h12345678, 1'b1, 2);
    chk("fault_no_access", n_mrd - n0, 32'd0);
    chk("fault_st_mem", rdw(2000), 32'hDEADBEEF);
    ld(2'b10, 1'b0, 32'd65533, 32'h0, 1'b1);
    preload(65532, 32'hCAFEF00D);
    ld(2'b10, 1'b0, 32'd65532, 32'hCAFEF00D, 1'b0);
    ld(2'b10, 1'b0, 32'd65536, 32'h0, 1'b1);
    ld(2'b11, 1'b0, 32'd1000, 32'h0, 1'b1);

    // Abort a byte store while it is in its write cycle.
    preload(2008, 32'h01020304);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'd2008; wdata = 32'hFF;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1;
    chk("rmw_wr_reached", {31'b0, mem_mwr}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {28'd0, ready, busy, fault, mem_mrd | mem_mwr}, 32'd0);
    chk("rst_mid_adr", mem_adr, 32'd0);
    chk("rst_mid_din", mem_d_in, 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    last_ld = 32'd0;
    chk("rst_mid_mem", rdw(2008), 32'h01020304);
    ld(2'b10, 1'b0, 32'd2008, 32'h01020304, 1'b0);

    // Continuous req with alternating word store/load.
    hw = '{1'b1, 1'b0, 1'b1, 1'b0};
    ha = '{32'd2012, 32'd2012, 32'd2016, 32'd2016};
    hd = '{32'h12345678, 32'h0, 32'h9ABCDEF0, 32'h0};
    @(negedge clk);
    i = 0; g = 0; lastacc = -1;
    req = 1'b1; wr = hw[0]; size = 2'b10; sext = 1'b0; addr = ha[0]; wdata = hd[0];
    while (i < 4 && g < 100) begin
      idle = !busy;
      @(posedge clk); #1;
      if (idle) begin
        if (hw[i]) sb.push_back('{last_ld, 1'b0});
        else begin last_ld = hd[i-1]; sb.push_back('{last_ld, 1'b0}); end
        n_issued++;
        if (lastacc >= 0) chk("issue_interval", g - lastacc, 32'd3);
        lastacc = g;
        i++;
        if (i < 4) begin wr = hw[i]; addr = ha[i]; wdata = hd[i]; end
      end
      @(negedge clk);
      g++;
    end
    req = 1'b0;
    chk("hs_accepts", i, 32'd4);
    repeat (6) @(negedge clk);
    chk("hs_mem", rdw(2016), 32'h9ABCDEF0);
    chk("sb_empty", sb.size(), 32'd0);
    chk("ready_count", n_ready, n_issued);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
